register_file_param: RTL and testbench

//  Parametrised 2-read/2-write register file for the core datapath; successor to the single-write regfile.

---
 rtl/register_file_param.sv | 132 +++++++++++++
 tb/tb_register_file_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// 2-read/2-write register file with a one-entry-per-cycle bulk clear engine (also run on reset).
// Define REGFILE_BYPASS_EN to forward same-cycle accepted writes to the read ports.

module register_file_param_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rd_data
);
  always_comb begin
    rd_data = arr_data;
    if (byp_hit) rd_data = byp_data;
    if (ZERO_REG != 0 && rd_addr == '0) rd_data = '0;
  end
endmodule

module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic [ADDR_W-1:0] Read_Addr_Port_1,
  output logic [DATA_W-1:0] Read_Data_Port_1,
  input  logic [ADDR_W-1:0] Read_Addr_Port_2,
  output logic [DATA_W-1:0] Read_Data_Port_2,
  input  logic [ADDR_W-1:0] Write_Addr_Port_1,
  input  logic [DATA_W-1:0] Write_Data_Port_1,
  input  logic              Wr_En_1,
  input  logic [ADDR_W-1:0] Write_Addr_Port_2,
  input  logic [DATA_W-1:0] Write_Data_Port_2,
  input  logic              Wr_En_2,
  input  logic              Clr_Req,
  output logic              Busy,
  output logic              Clr_Done,
  output logic              Wr_Drop
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam int              NUM_RD   = 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                we_1, we_2;

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_raw, rd_data, byp_data;
  logic [NUM_RD-1:0]             byp_hit;

  assign Busy     = (state == CLEARING);
  assign Clr_Done = Busy && (clr_idx == LAST_IDX);

  // Accepted writes: idle, enabled, and not aimed at a hardwired zero entry.
  assign we_1 = Wr_En_1 && !Busy && !(ZERO_REG != 0 && Write_Addr_Port_1 == '0);
  assign we_2 = Wr_En_2 && !Busy && !(ZERO_REG != 0 && Write_Addr_Port_2 == '0);

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      IDLE: if (Clr_Req) begin
        state_nxt   = CLEARING;
        clr_idx_nxt = '0;
      end
      CLEARING: begin
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (clr_idx == LAST_IDX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state   <= CLEARING;
      clr_idx <= '0;
      Wr_Drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      Wr_Drop <= Busy && (Wr_En_1 || Wr_En_2);
    end
  end

  // No reset on the array so it still maps to distributed RAM; port 2 wins by ordering.
  always_ff @(posedge Clk_Core) begin
    if (Busy) begin
      mem[clr_idx] <= '0;
    end else begin
      if (we_1) mem[Write_Addr_Port_1] <= Write_Data_Port_1;
      if (we_2) mem[Write_Addr_Port_2] <= Write_Data_Port_2;
    end
  end

  assign rd_addr[0]       = Read_Addr_Port_1;
  assign rd_addr[1]       = Read_Addr_Port_2;
  assign Read_Data_Port_1 = rd_data[0];
  assign Read_Data_Port_2 = rd_data[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_raw[p] = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
    logic hit_1, hit_2;
    assign hit_1       = we_1 && (Write_Addr_Port_1 == rd_addr[p]);
    assign hit_2       = we_2 && (Write_Addr_Port_2 == rd_addr[p]);
    assign byp_hit[p]  = hit_1 || hit_2;
    assign byp_data[p] = hit_2 ? Write_Data_Port_2 : Write_Data_Port_1;
`else
    assign byp_hit[p]  = 1'b0;
    assign byp_data[p] = '0;
`endif
  end

  register_file_param_rd #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
  ) u_rd [NUM_RD-1:0] (
    .rd_addr  (rd_addr),
    .arr_data (rd_raw),
    .byp_hit  (byp_hit),
    .byp_data (byp_data),
    .rd_data  (rd_data)
  );
endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: clear timing, write/read, port priority, zero reg,
// partial-clear visibility, dropped writes and reset restart.
module tb_register_file_param;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra_1, ra_2, wa_1, wa_2;
  logic [DW-1:0] wd_1, wd_2;
  logic          we_1, we_2, clr_req;
  logic [DW-1:0] rd_1, rd_2, nz_rd_1, nz_rd_2;
  logic          busy, clr_done, wr_drop, nz_busy, nz_done, nz_drop;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .Clk_Core(clk), .Rst_Core(rst),
    .Read_Addr_Port_1(ra_1), .Read_Data_Port_1(rd_1),
    .Read_Addr_Port_2(ra_2), .Read_Data_Port_2(rd_2),
    .Write_Addr_Port_1(wa_1), .Write_Data_Port_1(wd_1), .Wr_En_1(we_1),
    .Write_Addr_Port_2(wa_2), .Write_Data_Port_2(wd_2), .Wr_En_2(we_2),
    .Clr_Req(clr_req), .Busy(busy), .Clr_Done(clr_done), .Wr_Drop(wr_drop)
  );

  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_nz (
    .Clk_Core(clk), .Rst_Core(rst),
    .Read_Addr_Port_1(ra_1), .Read_Data_Port_1(nz_rd_1),
    .Read_Addr_Port_2(ra_2), .Read_Data_Port_2(nz_rd_2),
    .Write_Addr_Port_1(wa_1), .Write_Data_Port_1(wd_1), .Wr_En_1(we_1),
    .Write_Addr_Port_2(wa_2), .Write_Data_Port_2(wd_2), .Wr_En_2(we_2),
    .Clr_Req(clr_req), .Busy(nz_busy), .Clr_Done(nz_done), .Wr_Drop(nz_drop)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until Busy drops (bounded); optionally pulses Clr_Req at cycle req_at.
  task automatic run_clear(input int req_at, output int n, output int done_at, output int done_n);
    n = 0; done_at = -1; done_n = 0;
    while (busy && n < 64) begin
      if (clr_done) begin done_at = n; done_n++; end
      clr_req = (n == req_at);
      tick();
      clr_req = 1'b0;
      n++;
    end
  endtask

  int n, done_at, done_n;
  logic [DW-1:0] exp_byp;

  initial begin
    rst = 1'b1; clr_req = 1'b0;
    ra_1 = '0; ra_2 = '0; wa_1 = '0; wa_2 = '0; wd_1 = '0; wd_2 = '0;
    we_1 = 1'b0; we_2 = 1'b0;
    tick();
    rst = 1'b0;
    chk("busy_after_reset", busy, 1);
    chk("wr_drop_after_reset", wr_drop, 0);
    chk("done_after_reset", clr_done, 0);
    run_clear(-1, n, done_at, done_n);
    chk("reset_busy_cycles", n, 32);
    chk("reset_done_cycle", done_at, 31);
    chk("reset_done_count", done_n, 1);
    for (int a = 0; a < 32; a++) begin
      ra_1 = AW'(a); ra_2 = AW'(31 - a); #1;
      chk($sformatf("clr_r1_%0d", a), rd_1, 0);
      chk($sformatf("clr_r2_%0d", 31 - a), rd_2, 0);
    end

    // Single write, same-cycle and next-cycle read
    wa_1 = 5; wd_1 = 32'hDEADBEEF; we_1 = 1'b1; ra_1 = 5; #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hDEADBEEF;
`else
    exp_byp = 32'h0;
`endif
    chk("w5_same_cycle", rd_1, exp_byp);
    tick();
    we_1 = 1'b0; #1;
    chk("w5_next_cycle", rd_1, 32'hDEADBEEF);
    chk("wr_drop_idle", wr_drop, 0);

    // Both ports same address: port 2 wins
    wa_1 = 7; wd_1 = 32'h11; we_1 = 1'b1;
    wa_2 = 7; wd_2 = 32'h22; we_2 = 1'b1; ra_2 = 7; #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h22;
`else
    exp_byp = 32'h0;
`endif
    chk("w7_same_cycle", rd_2, exp_byp);
    tick();
    we_1 = 1'b0; we_2 = 1'b0; ra_1 = 7; #1;
    chk("w7_port2_wins", rd_1, 32'h22);

    // Zero register
    wa_1 = 0; wd_1 = 32'hFFFF; we_1 = 1'b1; ra_1 = 0; ra_2 = 0; #1;
    chk("zero_same_cycle", rd_1, 0);
    tick();
    we_1 = 1'b0; #1;
    chk("zero_r1", rd_1, 0);
    chk("zero_r2", rd_2, 0);
    chk("nz_addr0_r1", nz_rd_1, 32'hFFFF);
    chk("nz_addr0_r2", nz_rd_2, 32'hFFFF);

    // Fill every entry with 0x100+i
    for (int i = 0; i < 16; i++) begin
      wa_1 = AW'(2 * i);     wd_1 = 32'h100 + 32'(2 * i);     we_1 = 1'b1;
      wa_2 = AW'(2 * i + 1); wd_2 = 32'h100 + 32'(2 * i + 1); we_2 = 1'b1;
      tick();
    end
    we_1 = 1'b0; we_2 = 1'b0;
    ra_1 = 20; #1;
    chk("fill_20", rd_1, 32'h114);

    // Bulk clear: observe at k=5
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_req_busy", busy, 1);
    for (int k = 0; k < 5; k++) tick();
    ra_1 = 4; ra_2 = 5; #1;
    chk("partial_cleared_4", rd_1, 0);
    chk("partial_old_5", rd_2, 32'h105);
    ra_1 = 31; #1;
    chk("partial_old_31", rd_1, 32'h11F);
    wa_1 = 20; wd_1 = 32'hAAAA; we_1 = 1'b1;
    tick();                                  // k=6
    we_1 = 1'b0;
    chk("wr_drop_set", wr_drop, 1);
    clr_req = 1'b1;
    tick();                                  // k=7
    clr_req = 1'b0;
    chk("wr_drop_clear", wr_drop, 0);
    for (int k = 0; k < 3; k++) tick();      // k=10
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ra_1 = 20; ra_2 = 9; #1;
    chk("restart_busy", busy, 1);
    chk("dropped_write_ignored", rd_1, 32'h114);
    chk("already_cleared_9", rd_2, 0);
    run_clear(3, n, done_at, done_n);
    chk("restart_busy_cycles", n, 32);
    chk("restart_done_cycle", done_at, 31);
    chk("idle_after_restart", busy, 0);
    ra_1 = 20; ra_2 = 31; #1;
    chk("final_20", rd_1, 0);
    chk("final_31", rd_2, 0);
    chk("nz_final_31", nz_rd_2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
